// File: rtl/perf_sample_unit_pkg.sv
// Shared types and constants for the event-based sampling engine.
//   perf_sample_t       : one captured sample record (four 64-bit words)
//   perf_sample_state_e : drain FSM state encoding
//   sample_word()       : selects the word written on a given beat
package perf_sample_unit_pkg;

   localparam int unsigned PERF_SAMPLE_WORDS  = 4;
   localparam int unsigned PERF_TRIG_CYC      = 0;
   localparam int unsigned PERF_TRIG_INSTRET  = 1;
   localparam int unsigned PERF_TRIG_HPM_BASE = 2;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] cycle;
      logic [63:0] instret;
      logic [63:0] src;
   } perf_sample_t;

   typedef enum logic [1:0] {
      SMP_IDLE  = 2'd0,
      SMP_WRITE = 2'd1,
      SMP_FULL  = 2'd2
   } perf_sample_state_e;

   // Words leave in the order pc, cycle, instret, src.
   function automatic logic [63:0] sample_word(perf_sample_t s, logic [1:0] beat);
      logic [63:0] w;
      case (beat)
         2'd0:    w = s.pc;
         2'd1:    w = s.cycle;
         2'd2:    w = s.instret;
         default: w = s.src;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/perf_sample_unit_fifo.sv
// Sample record FIFO between trigger capture and the memory drain FSM.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   push_i, data_i    : write side (push ignored while full)
//   pop_i, data_o     : read side, data_o is the current head (pop ignored while empty)
//   full_o, empty_o   : occupancy flags, derived from the registered count
module perf_sample_unit_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter type         DATA_T = logic
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  push_i,
   input  DATA_T data_i,
   input  logic  pop_i,
   output DATA_T data_o,
   output logic  full_o,
   output logic  empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   DATA_T           mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   cnt_q;
   logic            do_push, do_pop;

   assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (PtrW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PtrW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset; validity is tracked by the count.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/perf_sample_unit.sv
// Event-based sampling engine. Captures {pc, cycle, instret, src} on each
// qualified trigger into a small FIFO and drains every record as four 64-bit
// writes into a memory ring at base_addr_i. Raises a sticky interrupt once the
// ring holds BufEntries records.
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   enable_i, debug_mode_i        : capture qualification
//   trigger_valid_i, trigger_src_i: threshold crossing and its source mask
//   pc_i, cycle_count_i, instr_count_i : values snapshotted per sample
//   base_addr_i                   : ring base, latched per record
//   mem_req_o/mem_gnt_i/mem_addr_o/mem_wdata_o : write port
//   sample_taken_o                : one-cycle pulse after an accepted trigger
//   full_irq_o, irq_clear_i       : sticky ring-full interrupt and its clear/rewind
//   wr_idx_o                      : records written since last clear
//   ovf_cnt_o                     : saturating dropped-sample count
//
// state     | meaning
// SMP_IDLE  | waiting for a queued record, or detecting ring full
// SMP_WRITE | emitting the latched record, one word per grant
// SMP_FULL  | ring full, interrupt raised, draining paused until clear
module perf_sample_unit
   import perf_sample_unit_pkg::*;
#(
   parameter int unsigned FifoDepth  = 4,
   parameter int unsigned BufEntries = 64,
   parameter int unsigned OvfWidth   = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        enable_i,
   input  logic                        debug_mode_i,
   input  logic                        trigger_valid_i,
   input  logic [7:0]                  trigger_src_i,
   input  logic [63:0]                 pc_i,
   input  logic [63:0]                 cycle_count_i,
   input  logic [63:0]                 instr_count_i,
   input  logic [63:0]                 base_addr_i,
   output logic                        mem_req_o,
   input  logic                        mem_gnt_i,
   output logic [63:0]                 mem_addr_o,
   output logic [63:0]                 mem_wdata_o,
   output logic                        sample_taken_o,
   output logic                        full_irq_o,
   input  logic                        irq_clear_i,
   output logic [$clog2(BufEntries):0] wr_idx_o,
   output logic [OvfWidth-1:0]         ovf_cnt_o
);

   localparam int unsigned           IdxW     = $clog2(BufEntries) + 1;
   localparam logic [IdxW-1:0]       FullIdx  = IdxW'(BufEntries);
   localparam logic [1:0]            LastBeat = 2'(PERF_SAMPLE_WORDS - 1);

   perf_sample_state_e state_q, state_d;
   logic [1:0]         beat_q, beat_d;
   perf_sample_t       rec_q, fifo_head, capture;
   logic [63:0]        rec_addr_q;
   logic [IdxW-1:0]    wr_idx_q;
   logic [OvfWidth-1:0] ovf_q;
   logic               full_irq_q, taken_q;
   logic               fifo_full, fifo_empty;
   logic               qualify, push, drop, pop, latch, set_full;

   assign qualify = trigger_valid_i & enable_i & ~debug_mode_i;
   assign push    = qualify & ~fifo_full;
   assign drop    = qualify & fifo_full;

   assign capture = '{pc: pc_i, cycle: cycle_count_i, instret: instr_count_i,
                      src: {56'b0, trigger_src_i}};

   perf_sample_unit_fifo #(
      .DEPTH  (FifoDepth),
      .DATA_T (perf_sample_t)
   ) i_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (capture),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      latch    = 1'b0;
      pop      = 1'b0;
      set_full = 1'b0;
      case (state_q)
         SMP_IDLE: begin
            // A clear this cycle rewinds the index; start fresh next cycle so the
            // record address is computed from the rewound index.
            if (!irq_clear_i) begin
               if (wr_idx_q == FullIdx) begin
                  state_d  = SMP_FULL;
                  set_full = 1'b1;
               end else if (!fifo_empty && !full_irq_q) begin
                  latch   = 1'b1;
                  beat_d  = 2'd0;
                  state_d = SMP_WRITE;
               end
            end
         end
         SMP_WRITE: begin
            if (mem_gnt_i) begin
               beat_d = beat_q + 2'd1;
               if (beat_q == LastBeat) begin
                  pop     = 1'b1;
                  state_d = SMP_IDLE;
               end
            end
         end
         SMP_FULL: begin
            if (irq_clear_i) state_d = SMP_IDLE;
         end
         default: state_d = SMP_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= SMP_IDLE;
         beat_q     <= '0;
         rec_q      <= '0;
         rec_addr_q <= '0;
         wr_idx_q   <= '0;
         ovf_q      <= '0;
         full_irq_q <= 1'b0;
         taken_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         taken_q <= push;
         if (latch) begin
            rec_q      <= fifo_head;
            // Record address is fixed here so a later rewind cannot move it.
            rec_addr_q <= base_addr_i + (64'(wr_idx_q) << 5);
         end
         if (irq_clear_i)  wr_idx_q <= '0;
         else if (pop)     wr_idx_q <= wr_idx_q + IdxW'(1);
         if (irq_clear_i)  full_irq_q <= 1'b0;
         else if (set_full) full_irq_q <= 1'b1;
         if (drop && (ovf_q != '1)) ovf_q <= ovf_q + OvfWidth'(1);
      end
   end

   assign mem_req_o      = (state_q == SMP_WRITE);
   assign mem_addr_o     = mem_req_o ? rec_addr_q + 64'({beat_q, 3'b000}) : 64'd0;
   assign mem_wdata_o    = mem_req_o ? sample_word(rec_q, beat_q) : 64'd0;
   assign sample_taken_o = taken_q;
   assign full_irq_o     = full_irq_q;
   assign wr_idx_o       = wr_idx_q;
   assign ovf_cnt_o      = ovf_q;

endmodule

// File: tb/tb_perf_sample_unit.sv
module tb_perf_sample_unit;

   localparam logic [63:0] BASE = 64'h0000_0000_9000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        enable_i, debug_mode_i, trigger_valid_i;
   logic [7:0]  trigger_src_i;
   logic [63:0] pc_i, cycle_count_i, instr_count_i, base_addr_i;
   logic        mem_req_o, mem_gnt_i;
   logic [63:0] mem_addr_o, mem_wdata_o;
   logic        sample_taken_o, full_irq_o, irq_clear_i;
   logic [2:0]  wr_idx_o;
   logic [15:0] ovf_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   perf_sample_unit #(
      .FifoDepth  (4),
      .BufEntries (4),
      .OvfWidth   (16)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .enable_i        (enable_i),
      .debug_mode_i    (debug_mode_i),
      .trigger_valid_i (trigger_valid_i),
      .trigger_src_i   (trigger_src_i),
      .pc_i            (pc_i),
      .cycle_count_i   (cycle_count_i),
      .instr_count_i   (instr_count_i),
      .base_addr_i     (base_addr_i),
      .mem_req_o       (mem_req_o),
      .mem_gnt_i       (mem_gnt_i),
      .mem_addr_o      (mem_addr_o),
      .mem_wdata_o     (mem_wdata_o),
      .sample_taken_o  (sample_taken_o),
      .full_irq_o      (full_irq_o),
      .irq_clear_i     (irq_clear_i),
      .wr_idx_o        (wr_idx_o),
      .ovf_cnt_o       (ovf_cnt_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a one-cycle trigger starting at the current negedge.
   task automatic pulse_trig(input logic [63:0] pc, input logic [63:0] cyc,
                             input logic [63:0] ins, input logic [7:0] src);
      pc_i = pc; cycle_count_i = cyc; instr_count_i = ins; trigger_src_i = src;
      trigger_valid_i = 1'b1;
      @(negedge clk_i);
      trigger_valid_i = 1'b0;
   endtask

   // Check one write beat at the current negedge, then advance one cycle.
   task automatic exp_beat(input string tag, input logic [63:0] addr, input logic [63:0] data);
      chk({tag, "_req"}, 64'(mem_req_o), 64'd1);
      chk({tag, "_addr"}, mem_addr_o, addr);
      chk({tag, "_data"}, mem_wdata_o, data);
      @(negedge clk_i);
   endtask

   // Full record with grant high: four beats then one idle cycle.
   task automatic exp_record(input string tag, input logic [63:0] addr, input logic [63:0] pc,
                             input logic [63:0] cyc, input logic [63:0] ins, input logic [63:0] src);
      exp_beat({tag, "_b0"}, addr,         pc);
      exp_beat({tag, "_b1"}, addr + 64'h8, cyc);
      exp_beat({tag, "_b2"}, addr + 64'h10, ins);
      exp_beat({tag, "_b3"}, addr + 64'h18, src);
      chk({tag, "_gap"}, 64'(mem_req_o), 64'd0);
      @(negedge clk_i);
   endtask

   initial begin
      rst_i = 1'b1; enable_i = 1'b1; debug_mode_i = 1'b0; trigger_valid_i = 1'b0;
      trigger_src_i = '0; pc_i = '0; cycle_count_i = '0; instr_count_i = '0;
      base_addr_i = BASE; mem_gnt_i = 1'b1; irq_clear_i = 1'b0;

      @(negedge clk_i);
      chk("rst_req", 64'(mem_req_o), 64'd0);
      chk("rst_taken", 64'(sample_taken_o), 64'd0);
      chk("rst_irq", 64'(full_irq_o), 64'd0);
      chk("rst_idx", 64'(wr_idx_o), 64'd0);
      chk("rst_ovf", 64'(ovf_cnt_o), 64'd0);
      chk("rst_addr", mem_addr_o, 64'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Single trigger, grant high.
      pulse_trig(64'h8000_1000, 64'h100, 64'h80, 8'h04);
      chk("s1_taken", 64'(sample_taken_o), 64'd1);
      @(negedge clk_i);
      chk("s1_taken_once", 64'(sample_taken_o), 64'd0);
      exp_record("s1", BASE, 64'h8000_1000, 64'h100, 64'h80, 64'h4);
      chk("s1_idx", 64'(wr_idx_o), 64'd1);

      // Grant withheld for 10 cycles during beat 1.
      pulse_trig(64'h8000_2000, 64'h200, 64'h150, 8'h02);
      @(negedge clk_i);
      exp_beat("s2_b0", BASE + 64'h20, 64'h8000_2000);
      mem_gnt_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         chk("s2_hold_req", 64'(mem_req_o), 64'd1);
         chk("s2_hold_addr", mem_addr_o, BASE + 64'h28);
         chk("s2_hold_data", mem_wdata_o, 64'h200);
      end
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      exp_beat("s2_b2", BASE + 64'h30, 64'h150);
      exp_beat("s2_b3", BASE + 64'h38, 64'h2);
      chk("s2_idx", 64'(wr_idx_o), 64'd2);

      // Rewind while idle.
      irq_clear_i = 1'b1;
      @(negedge clk_i);
      irq_clear_i = 1'b0;
      chk("clr_idx", 64'(wr_idx_o), 64'd0);

      // Six back-to-back triggers with grant low: four accepted, two dropped.
      mem_gnt_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         pulse_trig(64'h1000 + 64'(i), 64'h3000 + 64'(i), 64'h4000 + 64'(i), 8'(1 << i));
         chk($sformatf("s3_taken%0d", i), 64'(sample_taken_o), (i < 4) ? 64'd1 : 64'd0);
      end
      chk("s3_ovf", 64'(ovf_cnt_o), 64'd2);
      chk("s3_idx", 64'(wr_idx_o), 64'd0);
      mem_gnt_i = 1'b1;
      for (int i = 0; i < 4; i++)
         exp_record($sformatf("s3_r%0d", i), BASE + 64'(i * 32), 64'h1000 + 64'(i),
                    64'h3000 + 64'(i), 64'h4000 + 64'(i), 64'(1 << i));
      chk("s4_irq", 64'(full_irq_o), 64'd1);
      chk("s4_idx", 64'(wr_idx_o), 64'd4);

      // Fifth record held while full, then written at the base after clear.
      pulse_trig(64'h5555, 64'h6666, 64'h7777, 8'h80);
      chk("s4_taken", 64'(sample_taken_o), 64'd1);
      repeat (3) @(negedge clk_i);
      chk("s4_hold_req", 64'(mem_req_o), 64'd0);
      chk("s4_hold_irq", 64'(full_irq_o), 64'd1);
      irq_clear_i = 1'b1;
      @(negedge clk_i);
      irq_clear_i = 1'b0;
      chk("s4_clr_irq", 64'(full_irq_o), 64'd0);
      chk("s4_clr_idx", 64'(wr_idx_o), 64'd0);
      @(negedge clk_i);
      exp_record("s4_r5", BASE, 64'h5555, 64'h6666, 64'h7777, 64'h80);
      chk("s4_idx1", 64'(wr_idx_o), 64'd1);

      // Base change and clear mid-record; clear coincides with the beat-3 grant.
      pulse_trig(64'hA0, 64'hA1, 64'hA2, 8'h01);
      @(negedge clk_i);
      exp_beat("s5_b0", BASE + 64'h20, 64'hA0);
      base_addr_i = 64'hFFFF_0000;
      exp_beat("s5_b1", BASE + 64'h28, 64'hA1);
      irq_clear_i = 1'b1;
      exp_beat("s5_b2", BASE + 64'h30, 64'hA2);
      exp_beat("s5_b3", BASE + 64'h38, 64'h1);
      irq_clear_i = 1'b0;
      base_addr_i = BASE;
      chk("s5_idx", 64'(wr_idx_o), 64'd0);
      chk("s5_irq", 64'(full_irq_o), 64'd0);
      chk("s5_req", 64'(mem_req_o), 64'd0);

      // Debug mode and disabled triggers are ignored without counting drops.
      debug_mode_i = 1'b1;
      pulse_trig(64'hB0, 64'hB1, 64'hB2, 8'h08);
      chk("s6_dbg_taken", 64'(sample_taken_o), 64'd0);
      debug_mode_i = 1'b0;
      enable_i = 1'b0;
      pulse_trig(64'hC0, 64'hC1, 64'hC2, 8'h10);
      chk("s6_dis_taken", 64'(sample_taken_o), 64'd0);
      enable_i = 1'b1;
      repeat (2) @(negedge clk_i);
      chk("s6_req", 64'(mem_req_o), 64'd0);
      chk("s6_ovf", 64'(ovf_cnt_o), 64'd2);

      // Reset during beat 2 with a second record queued.
      pulse_trig(64'hD0, 64'hD1, 64'hD2, 8'h20);
      pulse_trig(64'hE0, 64'hE1, 64'hE2, 8'h40);
      exp_beat("s7_b0", BASE, 64'hD0);
      exp_beat("s7_b1", BASE + 64'h8, 64'hD1);
      chk("s7_b2_req", 64'(mem_req_o), 64'd1);
      rst_i = 1'b1;
      #1;
      chk("s7_rst_req", 64'(mem_req_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (4) @(negedge clk_i);
      chk("s7_post_req", 64'(mem_req_o), 64'd0);
      chk("s7_post_idx", 64'(wr_idx_o), 64'd0);
      chk("s7_post_ovf", 64'(ovf_cnt_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
